// File: rtl/afifo_wptr.sv
// Write-side pointer, full/almost-full and overflow logic for a 256-entry async FIFO; AFIFO_AFULL_EN adds almost-full.
// Latency: wen combinational from push; read pointer sync 2 cycles, full/afull/ovf registered one cycle after cause.
// Backpressure: push is ignored while registered full is high; pushes attempted while full set sticky ovf.
module afifo_wptr #(
    parameter int AFULL_LVL = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [8:0] rptr_gray_in,
    input  logic [8:0] rptr_bin,
    output logic [8:0] rptr_gray_sync,
    output logic [8:0] wptr_gray,
    output logic [7:0] waddr,
    output logic       wen,
    output logic       full,
    output logic       afull,
    output logic       ovf
);

    logic [8:0] s1;
    logic [8:0] s2;
    logic [8:0] wbin;
    logic [8:0] wbin_next;
    logic [8:0] wgray_next;
    logic       full_next;

    assign wen        = push & ~full;
    assign wbin_next  = wbin + {8'd0, wen};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    assign full_next  = (wgray_next == {~s2[8:7], s2[6:0]});

    assign rptr_gray_sync = s2;
    assign waddr          = wbin[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 9'd0;
            s2        <= 9'd0;
            wbin      <= 9'd0;
            wptr_gray <= 9'd0;
            full      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            s1        <= rptr_gray_in;
            s2        <= s1;
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= full_next;
            ovf       <= ovf | (push & full);
        end
    end

`ifdef AFIFO_AFULL_EN
    logic [8:0] fill_next;

    assign fill_next = wbin_next - rptr_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            afull <= 1'b0;
        end else begin
            afull <= (fill_next >= 9'(AFULL_LVL));
        end
    end
`else
    // Read-side binary pointer only feeds the almost-full level.
    logic unused_rptr_bin;

    assign unused_rptr_bin = ^rptr_bin;
    assign afull           = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_wptr.sv
// Directed bench for afifo_wptr: vector table for basic cycles, then fill/overflow/release and wrap sequences.
module tb_afifo_wptr;

    logic       clk;
    logic       rst;
    logic       push;
    logic [8:0] rptr_gray_in;
    logic [8:0] rptr_bin;
    logic [8:0] rptr_gray_sync;
    logic [8:0] wptr_gray;
    logic [7:0] waddr;
    logic       wen;
    logic       full;
    logic       afull;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    afifo_wptr #(.AFULL_LVL(240)) dut (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .rptr_gray_in  (rptr_gray_in),
        .rptr_bin      (rptr_bin),
        .rptr_gray_sync(rptr_gray_sync),
        .wptr_gray     (wptr_gray),
        .waddr         (waddr),
        .wen           (wen),
        .full          (full),
        .afull         (afull),
        .ovf           (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] to_gray(input int b);
        logic [8:0] v;
        v = 9'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [8:0] g2b(input logic [8:0] g);
        logic [8:0] b;
        b[8] = g[8];
        for (int i = 7; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // External gray-to-binary stage returning the synchronized read pointer.
    always_comb rptr_bin = g2b(rptr_gray_sync);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        push = 1'b0;
        rptr_gray_in = 9'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       push;
        logic [8:0] rg;
        logic       wen;
        logic [7:0] waddr;
        logic       full;
        logic       ovf;
        logic [8:0] wg;
        logic [8:0] sync;
    } vec_t;

    vec_t tbl[8];
    int   n;
    logic exp_afull;

    initial begin
        rst = 1'b1;
        push = 1'b0;
        rptr_gray_in = 9'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //          rst push rg      wen waddr full ovf wg      sync
        tbl[0] = '{1'b0, 1'b0, 9'h000, 1'b0, 8'd0, 1'b0, 1'b0, 9'h000, 9'h000};
        tbl[1] = '{1'b0, 1'b1, 9'h000, 1'b1, 8'd0, 1'b0, 1'b0, 9'h000, 9'h000};
        tbl[2] = '{1'b0, 1'b1, 9'h000, 1'b1, 8'd1, 1'b0, 1'b0, 9'h001, 9'h000};
        tbl[3] = '{1'b0, 1'b0, 9'h005, 1'b0, 8'd2, 1'b0, 1'b0, 9'h003, 9'h000};
        tbl[4] = '{1'b0, 1'b1, 9'h005, 1'b1, 8'd2, 1'b0, 1'b0, 9'h003, 9'h000};
        tbl[5] = '{1'b0, 1'b0, 9'h005, 1'b0, 8'd3, 1'b0, 1'b0, 9'h002, 9'h005};
        tbl[6] = '{1'b1, 1'b1, 9'h005, 1'b1, 8'd3, 1'b0, 1'b0, 9'h002, 9'h005};
        tbl[7] = '{1'b0, 1'b0, 9'h000, 1'b0, 8'd0, 1'b0, 1'b0, 9'h000, 9'h000};

        for (int i = 0; i < 8; i++) begin
            rst          = tbl[i].rst;
            push         = tbl[i].push;
            rptr_gray_in = tbl[i].rg;
            #1;
            chk($sformatf("vec%0d_wen", i), int'(wen), int'(tbl[i].wen));
            chk($sformatf("vec%0d_waddr", i), int'(waddr), int'(tbl[i].waddr));
            chk($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].full));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(tbl[i].ovf));
            chk($sformatf("vec%0d_wptr_gray", i), int'(wptr_gray), int'(tbl[i].wg));
            chk($sformatf("vec%0d_rptr_sync", i), int'(rptr_gray_sync), int'(tbl[i].sync));
            chk($sformatf("vec%0d_afull", i), int'(afull), 0);
            @(negedge clk);
        end

        // Idle after reset: every output stays zero.
        push = 1'b0;
        rst  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("idle%0d_outputs", i),
                int'({wen, full, afull, ovf, waddr, wptr_gray, rptr_gray_sync}), 0);
            @(negedge clk);
        end

        // Fill 256 entries with the reader parked at 0.
        for (int i = 0; i < 256; i++) begin
            push = 1'b1;
            #1;
`ifdef AFIFO_AFULL_EN
            exp_afull = (i >= 240);
`else
            exp_afull = 1'b0;
`endif
            chk($sformatf("fill%0d_waddr", i), int'(waddr), i);
            chk($sformatf("fill%0d_wen", i), int'(wen), 1);
            chk($sformatf("fill%0d_full", i), int'(full), 0);
            chk($sformatf("fill%0d_afull", i), int'(afull), int'(exp_afull));
            @(negedge clk);
        end
        push = 1'b0;
        #1;
        chk("full_after_256", int'(full), 1);
        chk("wptr_gray_full", int'(wptr_gray), 9'h180);
        chk("waddr_full", int'(waddr), 0);
        chk("ovf_before_257", int'(ovf), 0);

        // 257th push is rejected and flags overflow.
        push = 1'b1;
        #1;
        chk("wen_when_full", int'(wen), 0);
        @(negedge clk);
        push = 1'b0;
        #1;
        chk("ovf_set", int'(ovf), 1);
        chk("waddr_held", int'(waddr), 0);
        chk("wptr_gray_held", int'(wptr_gray), 9'h180);
        repeat (20) @(negedge clk);
        #1;
        chk("ovf_sticky", int'(ovf), 1);

        // One read: pointer takes 2 cycles to sync, full clears on the 3rd.
        rptr_gray_in = 9'h001;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rptr_sync_2cyc", int'(rptr_gray_sync), 9'h001);
        chk("full_still_2cyc", int'(full), 1);
        push = 1'b1;
        @(negedge clk);
        #1;
        chk("full_clear_3cyc", int'(full), 0);
        chk("no_accept_on_clear_edge", int'(waddr), 0);
        chk("wen_after_clear", int'(wen), 1);
        @(negedge clk);
        push = 1'b0;
        #1;
        chk("waddr_after_write", int'(waddr), 1);
        chk("wptr_gray_after_write", int'(wptr_gray), 9'h181);

        // Reader trails writer by 4 across the 511 -> 0 wrap.
        do_reset();
        n = 0;
        for (int i = 0; i < 600; i++) begin
            rptr_gray_in = to_gray((n >= 4) ? n - 4 : 0);
            push = 1'b1;
            #1;
            chk($sformatf("trk%0d_full", i), int'(full), 0);
            chk($sformatf("trk%0d_waddr", i), int'(waddr), n % 256);
            chk($sformatf("trk%0d_wptr_gray", i), int'(wptr_gray), int'(to_gray(n % 512)));
            if (n == 511) chk("wrap_gray_511", int'(wptr_gray), 9'h100);
            if (n == 512) chk("wrap_gray_512", int'(wptr_gray), 9'h000);
            @(negedge clk);
            n++;
        end
        push = 1'b0;
        #1;
        chk("trk_ovf", int'(ovf), 0);
        chk("trk_final_waddr", int'(waddr), 88);
        chk("trk_final_gray", int'(wptr_gray), 9'h074);
        chk("trk_afull", int'(afull), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/afifo_wptr.md
AFIFO_WPTR -- requirements
Module: afifo_wptr

Interface
REQ-001 SHALL have parameter AFULL_LVL, default 240, almost-full threshold in entries (1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port push  input  1  write request from producer.
REQ-005 SHALL have port rptr_gray_in  input  9  read-side gray pointer, asynchronous to clk.
REQ-006 SHALL have port rptr_bin  input  9  binary of rptr_gray_sync, returned from the external gray-to-binary stage.
REQ-007 SHALL have port rptr_gray_sync  output  9  synchronized read gray pointer, fed to the gray-to-binary stage.
REQ-008 SHALL have port wptr_gray  output  9  registered write gray pointer, sent to the read domain.
REQ-009 SHALL have port waddr  output  8  RAM write address, equal to wbin[7:0].
REQ-010 SHALL have port wen  output  1  RAM write strobe, push && !full, combinational.
REQ-011 SHALL have port full  output  1  FIFO full, registered.
REQ-012 SHALL have port afull  output  1  almost full, registered.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL synchronize rptr_gray_in through two flops (s1, s2); rptr_gray_sync = s2, giving 2-cycle latency.
REQ-015 SHALL hold an internal 9-bit binary pointer wbin; wbin_next = wbin + 1 (mod 512) when wen = 1, else wbin.
REQ-016 SHALL register wptr_gray <= wbin_next ^ (wbin_next >> 1), so wptr_gray stays consistent with wbin every cycle.
REQ-017 SHALL register full <= (gray(wbin_next) == {~s2[8:7], s2[6:0]}); full rises the cycle after the push that fills entry 256.
REQ-018 SHALL block writes while full = 1: push is ignored, and wbin, waddr, and wptr_gray are held.
REQ-019 SHALL set ovf <= 1 on push && full; ovf stays set until reset.
REQ-020 SHALL deassert full on the first edge where the compare in REQ-017 fails, i.e. 3 cycles after rptr_gray_in advances.
REQ-021 SHALL wrap wbin 511 -> 0 seamlessly, with no glitch on full or afull.
REQ-022 SHALL, when push is high on the same edge that full clears, accept nothing on that edge; acceptance follows the registered full value only.

Reset
REQ-023 SHALL clear s1, s2, wbin, wptr_gray, full, afull, and ovf to 0 on the edge where rst = 1.
REQ-024 SHALL give rst priority over push; a push during reset is discarded and ovf is not set.
REQ-025 SHALL, after reset deasserts, make waddr = 0 and wen follow push.

Configuration
REQ-026 SHALL compile almost-full logic only when macro AFIFO_AFULL_EN is defined.
REQ-027 SHALL, with AFIFO_AFULL_EN defined, register afull <= ((wbin_next - rptr_bin) mod 512) >= AFULL_LVL.
REQ-028 SHALL, without AFIFO_AFULL_EN, tie afull to 0; rptr_bin is then unused and no subtractor is synthesized.

Verification
REQ-029 Reset then idle with push = 0 -> all outputs 0, and wptr_gray = 9'h000 for 10 cycles.
REQ-030 rptr_gray_in = 0, then 256 consecutive pushes -> waddr runs 0..255; full = 1 the cycle after the 256th push; wptr_gray = 9'h180.
REQ-031 Continue the REQ-030 state with a 257th push -> wen = 0, waddr = 0 held, ovf = 1 next cycle and still 1 after 20 further cycles.
REQ-032 From full, set rptr_gray_in = 9'h001 (one read) -> rptr_gray_sync = 9'h001 after 2 cycles; full = 0 after 3 cycles; the next push writes waddr 0.
REQ-033 Reader tracks writer at depth 4 for 600 pushes -> wbin wraps 511 -> 0 and wptr_gray wraps 9'h100 -> 9'h000; full never asserts; ovf = 0.
REQ-034 With AFIFO_AFULL_EN defined, AFULL_LVL = 240, rptr_bin = 0, 240 pushes -> afull = 1 the cycle after the 240th push, and not before; with the macro undefined, afull = 0 throughout.
